gpio_port_ctrl: RTL and testbench
=================================

GPIO_PORT_CTRL -- requirements
Module: gpio_port_ctrl

Interface
REQ-001 SHALL have parameter PORT_NUM, default 8, number of io pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGE, default 2, input synchronizer depth (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 0, debounce hold count (0 = bypass, max 255).
REQ-004 SHALL have port `clock`  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port `reset`  in  1  synchronous, active-low reset.
REQ-006 SHALL have port `io`  inout  PORT_NUM  pins.
REQ-007 SHALL have ports `din_valid` in 1, `din_ready` out 1 and `din` in PORT_NUM: output-value write channel.
REQ-008 SHALL have ports `dout_valid` out 1, `dout_ready` in 1 and `dout` out PORT_NUM: input-change notify channel.
REQ-009 SHALL have ports `cfg_valid` in 1, `cfg_ready` out 1, `cfg_addr` in 2 and `cfg_data` in 2*PORT_NUM: config write channel.
REQ-010 SHALL have ports `ir_valid` out PORT_NUM+1 and `ir_ready` in PORT_NUM+1: per-pin interrupts, with bit PORT_NUM as the summary interrupt.

Function
REQ-011 Config regs: addr0 dir (1 = output), addr1 en, addr2 ir_en (each uses cfg_data[PORT_NUM-1:0]), addr3 mode, 2 bits per pin (00 low level, 01 posedge, 10 negedge, 11 any edge).
REQ-012 Config writes: a transfer occurs when cfg_valid && cfg_ready; the new value takes effect from the next cycle.
REQ-013 din transfer: loads the out register; din_ready is 1 whenever not in reset.
REQ-014 io[i] drive: io[i] = out[i] when en[i] && dir[i], else high-Z.
REQ-015 Input path: each pin passes through SYNC_STAGE flops, then the debounce stage.
REQ-016 Debounce update: filtered[i] takes the synchronizer value at the (DEBOUNCE_CYC+1)-th consecutive edge on which the two differ.
REQ-017 Debounce counter: the counter clears whenever the synchronizer value equals filtered[i].
REQ-018 Debounce latency: a pin change appears in filtered exactly SYNC_STAGE+DEBOUNCE_CYC+1 edges after the change.
REQ-019 Edge detection: events compare filtered against filtered_d (filtered delayed one cycle).
REQ-020 Edge detection continues during mode/ir_en changes, so no spurious edge is produced.
REQ-021 Pending set: pend[i] is set at the edge after a matching event while ir_en[i] && en[i] && !dir[i].
REQ-022 Low-level pending: in low-level mode, pend[i] is set every cycle filtered[i] == 0.
REQ-023 ir_valid[i] = pend[i] for i < PORT_NUM.
REQ-024 Per-pin clear: ir_valid[i] && ir_ready[i] clears pend[i].
REQ-025 Set wins: when a set condition and a clear occur in the same cycle, pend[i] stays 1.
REQ-026 Summary interrupt: ir_valid[PORT_NUM] = |pend.
REQ-027 Summary clear: a summary handshake clears all pend bits, with set-wins applied per bit.
REQ-028 ir_en write: writing ir_en clears pend bits whose new ir_en bit is 0, in the same edge the write takes effect.
REQ-029 dout value: dout = filtered & en & ~dir (other bits 0).
REQ-030 dout_valid assert: dout_valid asserts when that value differs from last_sent.
REQ-031 dout hold: dout and dout_valid are held stable while dout_valid && !dout_ready.
REQ-032 dout handshake: last_sent is updated on handshake.
REQ-033 dout refresh: if the value changed during the stall, a new transfer follows the next cycle.

Reset
REQ-034 Reset state: while reset == 0 at an edge, dir, en, ir_en, mode, out, filtered, filtered_d, sync flops, debounce counters, pend, last_sent, dout and dout_valid all go to 0; all io are high-Z.
REQ-035 Ready during reset: din_ready and cfg_ready are 0 during reset and 1 from the first edge with reset == 1.
REQ-036 Reset mid-transfer: reset asserted mid-transfer aborts the transfer; no partial config or out update is kept.

Structure
REQ-037 Shared package gpio_pkg SHALL hold the mode encodings (MODE_LOW, MODE_POS, MODE_NEG, MODE_ANY) and the config address constants (CFG_DIR, CFG_EN, CFG_IREN, CFG_MODE).
REQ-038 Sub-module gpio_pin_filter (one pin: synchronizer, debounce counter, filtered/filtered_d outputs) SHALL be instantiated PORT_NUM times via generate.

Verification (PORT_NUM=8, SYNC_STAGE=2, DEBOUNCE_CYC=3)
REQ-039 Output drive: cfg dir=0x0F, en=0xFF, then din=0xA5 -> io[3:0]=0x5 next cycle; io[7:4] high-Z.
REQ-040 Debounce: pin4 0->1 held for 10 cycles -> filtered[4]=1 at edge 6; a 3-cycle glitch -> no change, no dout_valid.
REQ-041 Posedge interrupt: mode pin5=01, ir_en=0x20, pin5 rises -> ir_valid[5] and ir_valid[8] high 7 edges later; ir_ready[5] pulse -> both low next cycle.
REQ-042 Low-level interrupt: mode pin6=00, pin6 held low, ir_ready[6] pulsed -> ir_valid[6] drops 0 cycles (set wins) and stays 1.
REQ-043 dout stall: pin4 then pin5 change with dout_ready=0 -> dout holds the first value; ready=1 -> a second transfer with both bits.
REQ-044 Reset mid-operation: reset low mid-config/interrupt -> all outputs 0/high-Z next edge; din_ready rises the first edge after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared encodings for the GPIO port controller.
//   mode_e     - per-pin interrupt trigger mode (2 bits per pin)
//   cfg_addr_e - config register addresses on the cfg write channel
//   event_match - decides whether a pin's filtered history matches its mode
package gpio_pkg;

    typedef enum logic [1:0] {
        MODE_LOW = 2'b00,
        MODE_POS = 2'b01,
        MODE_NEG = 2'b10,
        MODE_ANY = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CFG_DIR  = 2'd0,
        CFG_EN   = 2'd1,
        CFG_IREN = 2'd2,
        CFG_MODE = 2'd3
    } cfg_addr_e;

    // f is the current filtered level, fd the same level one cycle earlier.
    function automatic logic event_match(input logic [1:0] mode, input logic f,
                                         input logic fd);
        logic hit;
        hit = 1'b0;
        unique case (mode_e'(mode))
            MODE_LOW: hit = ~f;
            MODE_POS: hit = f & ~fd;
            MODE_NEG: hit = ~f & fd;
            MODE_ANY: hit = f ^ fd;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// gpio_port_ctrl_if: handshake channels of the GPIO port controller.
//   din*  - output-value write channel (master -> controller)
//   dout* - input-change notify channel (controller -> master)
//   cfg*  - config write channel (master -> controller)
//   ir*   - per-pin interrupts, bit PORT_NUM is the summary interrupt
interface gpio_port_ctrl_if #(
    parameter int unsigned PORT_NUM = 8
);
    logic                    din_valid;
    logic                    din_ready;
    logic [PORT_NUM-1:0]     din;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [PORT_NUM-1:0]     dout;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [1:0]              cfg_addr;
    logic [2*PORT_NUM-1:0]   cfg_data;
    logic [PORT_NUM:0]       ir_valid;
    logic [PORT_NUM:0]       ir_ready;

    modport master (
        output din_valid, din, dout_ready, cfg_valid, cfg_addr, cfg_data, ir_ready,
        input  din_ready, dout_valid, dout, cfg_ready, ir_valid
    );

    modport slave (
        input  din_valid, din, dout_ready, cfg_valid, cfg_addr, cfg_data, ir_ready,
        output din_ready, dout_valid, dout, cfg_ready, ir_valid
    );
endinterface

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: one input pin's conditioning path.
//   clock/reset   - rising-edge clock, synchronous active-low reset
//   i_pin         - raw pin level
//   o_filtered    - synchronized and debounced level
//   o_filtered_d  - o_filtered delayed by one cycle (for edge detection)
// A change reaches o_filtered SYNC_STAGE+DEBOUNCE_CYC+1 edges after the pin moves.
module gpio_pin_filter #(
    parameter int unsigned SYNC_STAGE   = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_filtered,
    output logic o_filtered_d
);

    logic [SYNC_STAGE-1:0] r_sync;
    logic [7:0]            r_cnt;
    logic                  r_filt;
    logic                  r_filt_d;
    logic                  w_sync;

    assign w_sync = r_sync[SYNC_STAGE-1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGE-2:0], i_pin};
            r_filt_d <= r_filt;
            // Counter counts consecutive disagreeing edges; the (N+1)-th one commits.
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == 8'(DEBOUNCE_CYC)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_filtered   = r_filt;
    assign o_filtered_d = r_filt_d;

endmodule

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: configurable GPIO port with input-change notify and interrupts.
//   clock/reset - rising-edge clock, synchronous active-low reset
//   io          - bidirectional pins, driven only when en & dir
//   bus         - din / dout / cfg / ir handshake channels (slave side)
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned PORT_NUM     = 8,
    parameter int unsigned SYNC_STAGE   = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    inout  wire  [PORT_NUM-1:0]  io,
    gpio_port_ctrl_if.slave      bus
);

    logic                  r_rdy;
    logic [PORT_NUM-1:0]   r_dir, r_en, r_iren, r_out, r_pend, r_last_sent, r_dout;
    logic [2*PORT_NUM-1:0] r_mode;
    logic                  r_dout_valid;

    logic [PORT_NUM-1:0]   w_filt, w_filt_d, w_set, w_clr, w_pend_d;
    logic [PORT_NUM-1:0]   w_dout_val, w_sent_d;
    logic                  w_cfg_fire, w_din_fire, w_dout_fire, w_dout_adv;

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGE   (SYNC_STAGE),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_filter (
            .clock        (clock),
            .reset        (reset),
            .i_pin        (io[gi]),
            .o_filtered   (w_filt[gi]),
            .o_filtered_d (w_filt_d[gi])
        );

        assign io[gi]    = (r_en[gi] && r_dir[gi]) ? r_out[gi] : 1'bz;
        assign w_set[gi] = event_match(r_mode[2*gi +: 2], w_filt[gi], w_filt_d[gi])
                           & r_iren[gi] & r_en[gi] & ~r_dir[gi];
    end

    always_comb begin
        w_cfg_fire  = bus.cfg_valid && r_rdy;
        w_din_fire  = bus.din_valid && r_rdy;
        // Per-pin handshakes plus a summary handshake that clears everything.
        w_clr       = (r_pend & bus.ir_ready[PORT_NUM-1:0])
                      | {PORT_NUM{(|r_pend) & bus.ir_ready[PORT_NUM]}};
        w_pend_d    = (r_pend & ~w_clr) | w_set;
        // Disabling an interrupt drops its pending bit on the same edge.
        if (w_cfg_fire && (bus.cfg_addr == CFG_IREN)) begin
            w_pend_d = w_pend_d & bus.cfg_data[PORT_NUM-1:0];
        end

        w_dout_val  = w_filt & r_en & ~r_dir;
        w_dout_fire = r_dout_valid && bus.dout_ready;
        w_dout_adv  = !r_dout_valid || bus.dout_ready;
        w_sent_d    = w_dout_fire ? r_dout : r_last_sent;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rdy        <= 1'b0;
            r_dir        <= '0;
            r_en         <= '0;
            r_iren       <= '0;
            r_mode       <= '0;
            r_out        <= '0;
            r_pend       <= '0;
            r_last_sent  <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_cfg_fire) begin
                unique case (cfg_addr_e'(bus.cfg_addr))
                    CFG_DIR:  r_dir  <= bus.cfg_data[PORT_NUM-1:0];
                    CFG_EN:   r_en   <= bus.cfg_data[PORT_NUM-1:0];
                    CFG_IREN: r_iren <= bus.cfg_data[PORT_NUM-1:0];
                    CFG_MODE: r_mode <= bus.cfg_data;
                endcase
            end
            if (w_din_fire) begin
                r_out <= bus.din;
            end
            r_pend      <= w_pend_d;
            r_last_sent <= w_sent_d;
            // Hold while stalled; otherwise reload and compare with what was last taken.
            if (w_dout_adv) begin
                r_dout       <= w_dout_val;
                r_dout_valid <= (w_dout_val != w_sent_d);
            end
        end
    end

    assign bus.din_ready  = r_rdy;
    assign bus.cfg_ready  = r_rdy;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.ir_valid   = {|r_pend, r_pend};

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: directed bench for gpio_port_ctrl (PORT_NUM=8, SYNC_STAGE=2,
// DEBOUNCE_CYC=3). dout transfers are checked by a scoreboard queue; levels on io and
// ir_valid are checked directly. Pins 7:4 are driven by the bench, pins 3:0 by the DUT.
module tb_gpio_port_ctrl;
    import gpio_pkg::*;

    logic       clock;
    logic       reset;
    wire  [7:0] io;
    logic [7:0] tb_oe;
    logic [7:0] tb_val;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic       saw_valid;

    gpio_port_ctrl_if #(.PORT_NUM(8)) bus ();

    gpio_port_ctrl #(
        .PORT_NUM     (8),
        .SYNC_STAGE   (2),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io),
        .bus   (bus)
    );

    for (genvar k = 0; k < 8; k++) begin : g_drv
        assign io[k] = tb_oe[k] ? tb_val[k] : 1'bz;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Undriven pins read z in a 4-state simulator and 0 in a 2-state one.
    task automatic check_z(input string name, input logic [3:0] got);
        n_tests++;
        if (!(got === 4'hz || got === 4'h0)) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected high-Z", name, got);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_data  = data;
        step(1);
        bus.cfg_valid = 1'b0;
    endtask

    // Scoreboard monitor: one pop per dout handshake.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            #2;
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dout_unexpected: got 0x%0h expected no transfer", bus.dout);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.dout !== exp) begin
                        n_fail++;
                        $display("FAIL dout_xfer: got 0x%0h expected 0x%0h", bus.dout, exp);
                    end
                end
            end
        end
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        tb_oe          = 8'hF0;
        tb_val         = 8'h40;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.ir_ready   = '0;

        // Reset state
        step(3);
        check("rst_din_ready", bus.din_ready, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_ir_valid", bus.ir_valid, 0);
        check_z("rst_io_lo", io[3:0]);
        reset = 1'b1;
        step(1);
        check("rel_din_ready", bus.din_ready, 1);
        check("rel_cfg_ready", bus.cfg_ready, 1);
        step(10);

        // Output drive; enabling inputs reports pin6 which is already high
        exp_q.push_back(8'h40);
        cfg_write(CFG_DIR, 16'h000F);
        cfg_write(CFG_EN, 16'h00FF);
        bus.din_valid = 1'b1;
        bus.din       = 8'hA5;
        step(1);
        bus.din_valid = 1'b0;
        check("drive_io_lo", io[3:0], 4'h5);
        check("drive_io_hi", io[7:4], 4'h4);
        step(10);

        // Debounce latency: filtered at edge 6, dout_valid at edge 7
        tb_val[4] = 1'b1;
        exp_q.push_back(8'h50);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 6) check("deb_edge6_quiet", bus.dout_valid, 0);
            if (k == 7) begin
                check("deb_edge7_valid", bus.dout_valid, 1);
                check("deb_edge7_dout", bus.dout, 8'h50);
            end
        end
        step(3);
        tb_val[4] = 1'b0;
        exp_q.push_back(8'h40);
        step(10);

        // 3-cycle glitch must be rejected
        tb_val[4] = 1'b1;
        step(3);
        tb_val[4] = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (bus.dout_valid) saw_valid = 1'b1;
        end
        check("glitch_no_valid", saw_valid, 0);

        // Posedge interrupt on pin5
        cfg_write(CFG_MODE, 16'h0400);
        cfg_write(CFG_IREN, 16'h0020);
        tb_val[5] = 1'b1;
        exp_q.push_back(8'h60);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 6) check("pos_edge6_quiet", bus.ir_valid[5], 0);
            if (k == 7) begin
                check("pos_edge7_pin", bus.ir_valid[5], 1);
                check("pos_edge7_sum", bus.ir_valid[8], 1);
            end
        end
        bus.ir_ready = 9'h020;
        step(1);
        bus.ir_ready = '0;
        check("pos_clr_pin", bus.ir_valid[5], 0);
        check("pos_clr_sum", bus.ir_valid[8], 0);
        tb_val[5] = 1'b0;
        exp_q.push_back(8'h40);
        step(10);
        check("pos_fall_no_irq", bus.ir_valid, 0);

        // Low-level interrupt on pin6: set wins over clear
        cfg_write(CFG_IREN, 16'h0040);
        tb_val[6] = 1'b0;
        exp_q.push_back(8'h00);
        step(9);
        check("lvl_pin", bus.ir_valid[6], 1);
        check("lvl_sum", bus.ir_valid[8], 1);
        bus.ir_ready = 9'h040;
        step(1);
        bus.ir_ready = '0;
        check("lvl_set_wins", bus.ir_valid[6], 1);
        step(2);
        check("lvl_stays", bus.ir_valid[6], 1);
        cfg_write(CFG_IREN, 16'h0000);
        check("iren_write_clears", bus.ir_valid, 0);

        // dout stall: first value held, second transfer after ready
        bus.dout_ready = 1'b0;
        tb_val[4]      = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h30);
        step(7);
        check("stall_valid", bus.dout_valid, 1);
        check("stall_dout", bus.dout, 8'h10);
        tb_val[5] = 1'b1;
        step(10);
        check("stall_hold_valid", bus.dout_valid, 1);
        check("stall_hold_dout", bus.dout, 8'h10);
        bus.dout_ready = 1'b1;
        step(4);
        check("stall_drained", bus.dout_valid, 0);

        // Reset in the middle of a config write with an interrupt pending
        cfg_write(CFG_IREN, 16'h0040);
        step(2);
        check("pre_rst_irq", bus.ir_valid[6], 1);
        reset         = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = CFG_DIR;
        bus.cfg_data  = 16'h00FF;
        bus.din_valid = 1'b1;
        bus.din       = 8'hFF;
        step(1);
        check("mid_rst_ir_valid", bus.ir_valid, 0);
        check("mid_rst_dout_valid", bus.dout_valid, 0);
        check("mid_rst_din_ready", bus.din_ready, 0);
        check("mid_rst_cfg_ready", bus.cfg_ready, 0);
        check_z("mid_rst_io_lo", io[3:0]);
        step(1);
        reset = 1'b1;
        step(1);
        bus.cfg_valid = 1'b0;
        bus.din_valid = 1'b0;
        check("post_rst_din_ready", bus.din_ready, 1);
        cfg_write(CFG_DIR, 16'h000F);
        cfg_write(CFG_EN, 16'h000F);
        check("post_rst_out_cleared", io[3:0], 4'h0);
        step(5);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
